// File: rtl/printer_pkg.sv
// printer_pkg: shared FSM states, job record and page-code constants for the print spooler
package printer_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HALT, DONE} state_t;
    typedef struct packed {
        logic       color;
        logic [1:0] pages;
    } job_t;
    localparam logic [1:0] PAGE_ILLEGAL = 2'b00;
endpackage

// File: rtl/print_job_queue_if.sv
// print_job_queue_if: request, engine and status signals of the print spooler
interface print_job_queue_if #(parameter int CNT_W = 4);
    logic             prendido;
    logic             req_valid;
    logic             req_color;
    logic [1:0]       req_pages;
    logic             fin_color;
    logic             fin_negro;
    logic             error_color;
    logic             error_negro;
    logic             start_color;
    logic             start_negro;
    logic [1:0]       pagina;
    logic             busy;
    logic             halted;
    logic             queue_full;
    logic             queue_empty;
    logic             req_drop;
    logic [CNT_W-1:0] jobs_done;
    modport master (
        output prendido, req_valid, req_color, req_pages,
        output fin_color, fin_negro, error_color, error_negro,
        input  start_color, start_negro, pagina, busy, halted,
        input  queue_full, queue_empty, req_drop, jobs_done
    );
    modport slave (
        input  prendido, req_valid, req_color, req_pages,
        input  fin_color, fin_negro, error_color, error_negro,
        output start_color, start_negro, pagina, busy, halted,
        output queue_full, queue_empty, req_drop, jobs_done
    );
endinterface

// File: rtl/job_fifo.sv
// job_fifo: small power-of-two FIFO of print jobs with synchronous flush
module job_fifo
    import printer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  job_t din,
    output logic full,
    output logic empty,
    output job_t head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    job_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    // pointers wrap naturally at DEPTH; flush drops every queued job
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // storage needs no reset; only entries inside the count are ever read
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= din;
    end
    assign head  = mem[rd_ptr];
    assign full  = count == FULL_CNT;
    assign empty = count == '0;
endmodule

// File: rtl/print_job_queue.sv
// print_job_queue: buffers print requests and issues them one at a time to the color/black engines
module print_job_queue
    import printer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input logic CLK,
    input logic reset,
    print_job_queue_if.slave bus
);
    state_t           state, state_nx;
    job_t             cur, head, din;
    logic             push, pop, full, empty, drop, sel_fin, sel_err;
    logic [CNT_W-1:0] done_cnt;
    // full is the pre-pop status, so a request against a full queue is dropped even if a pop happens
    assign push    = bus.req_valid & bus.prendido & ~full & (bus.req_pages != PAGE_ILLEGAL);
    assign pop     = (state == IDLE) & bus.prendido & ~empty;
    assign din     = job_t'({bus.req_color, bus.req_pages});
    assign sel_fin = cur.color ? bus.fin_color : bus.fin_negro;
    assign sel_err = cur.color ? bus.error_color : bus.error_negro;
    job_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (~bus.prendido),
        .din   (din),
        .full  (full),
        .empty (empty),
        .head  (head)
    );
    // job lifecycle: power loss forces IDLE, fin beats error while waiting
    always_comb begin
        state_nx = state;
        if (!bus.prendido) state_nx = IDLE;
        else begin
            case (state)
                IDLE:    state_nx = empty ? IDLE : ISSUE;
                ISSUE:   state_nx = WAIT;
                WAIT:    state_nx = sel_fin ? DONE : (sel_err ? HALT : WAIT);
                HALT:    state_nx = sel_err ? HALT : WAIT;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end
    // state, current job, drop pulse and completion counter
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cur      <= '0;
            drop     <= 1'b0;
            done_cnt <= '0;
        end else begin
            state <= state_nx;
            drop  <= bus.req_valid & ~push;
            if (!bus.prendido || state == DONE) cur <= '0;
            else if (pop) cur <= head;
            if (bus.prendido && state == DONE) done_cnt <= done_cnt + 1'b1;
        end
    end
    assign bus.start_color = (state == ISSUE) & cur.color;
    assign bus.start_negro = (state == ISSUE) & ~cur.color;
    assign bus.pagina      = cur.pages;
    assign bus.busy        = state != IDLE;
    assign bus.halted      = state == HALT;
    assign bus.queue_full  = full;
    assign bus.queue_empty = empty;
    assign bus.req_drop    = drop;
    assign bus.jobs_done   = done_cnt;
endmodule

// File: tb/tb_print_job_queue.sv
// tb_print_job_queue: directed and random checks of the print spooler against a job-queue model
module tb_print_job_queue;
    import printer_pkg::*;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    logic CLK = 1'b0;
    logic reset;
    print_job_queue_if #(.CNT_W(CNT_W)) bus();
    print_job_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );
    always #5 CLK = ~CLK;

    // reference model: queued jobs plus the one job in service and its phase
    // mst: 0 start cycle, 1 waiting on engine, 2 out of ink, 3 completing
    job_t mq[$];
    job_t mj;
    bit   mv;
    int   mst;
    int   mdone;
    bit   mdrop;
    int   vecs;
    int   errs;

    logic [2:0]       starts[$];
    int               ndrops;
    int               nwrap;
    logic [CNT_W-1:0] prev_jd;

    // observe start pulses, drop pulses and counter wraps once per cycle
    always @(negedge CLK) begin
        if (!reset) begin
            if (bus.start_color || bus.start_negro) starts.push_back({bus.start_color, bus.pagina});
            if (bus.req_drop) ndrops++;
            if (bus.jobs_done == '0 && prev_jd == '1) nwrap++;
            prev_jd = bus.jobs_done;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("start_color", 32'(bus.start_color), 32'(mv && mst == 0 && mj.color));
        chk("start_negro", 32'(bus.start_negro), 32'(mv && mst == 0 && !mj.color));
        chk("pagina", 32'(bus.pagina), mv ? 32'(mj.pages) : 32'd0);
        chk("busy", 32'(bus.busy), 32'(mv));
        chk("halted", 32'(bus.halted), 32'(mv && mst == 2));
        chk("queue_empty", 32'(bus.queue_empty), 32'(mq.size() == 0));
        chk("queue_full", 32'(bus.queue_full), 32'(mq.size() == DEPTH));
        chk("req_drop", 32'(bus.req_drop), 32'(mdrop));
        chk("jobs_done", 32'(bus.jobs_done), 32'(mdone % (1 << CNT_W)));
    endtask

    task automatic model_reset();
        mq.delete();
        mv = 0;
        mst = 0;
        mdone = 0;
        mdrop = 0;
    endtask

    task automatic tick();
        job_t nj;
        int   osz;
        bit   acc, fs, es;
        @(posedge CLK);
        osz = mq.size();
        acc = bus.req_valid && bus.prendido && bus.req_pages != 2'd0 && osz < DEPTH;
        mdrop = bus.req_valid && !acc;
        if (!bus.prendido) begin
            mq.delete();
            mv = 0;
            mst = 0;
        end else begin
            fs = mj.color ? bus.fin_color : bus.fin_negro;
            es = mj.color ? bus.error_color : bus.error_negro;
            if (!mv) begin
                if (osz > 0) begin
                    mj = mq.pop_front();
                    mv = 1;
                    mst = 0;
                end
            end else begin
                case (mst)
                    0: mst = 1;
                    1: mst = fs ? 3 : (es ? 2 : 1);
                    2: mst = es ? 2 : 1;
                    default: begin
                        mv = 0;
                        mdone++;
                    end
                endcase
            end
            if (acc) begin
                nj.color = bus.req_color;
                nj.pages = bus.req_pages;
                mq.push_back(nj);
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic req(input logic c, input logic [1:0] p);
        bus.req_valid = 1'b1;
        bus.req_color = c;
        bus.req_pages = p;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic job_fin();
        bus.fin_color = 1'b1;
        bus.fin_negro = 1'b1;
        tick();
        bus.fin_color = 1'b0;
        bus.fin_negro = 1'b0;
        tick();
    endtask

    task automatic serve();
        int n = 0;
        while (!(bus.start_color || bus.start_negro) && n < 20) begin
            tick();
            n++;
        end
        chk("serve_start_seen", 32'(n < 20), 32'd1);
        tick();
        job_fin();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, nd0, nh, ns, jd_keep, nw0;
        logic [2:0] exp_jobs [5];
        exp_jobs[0] = 3'b1_11;
        exp_jobs[1] = 3'b0_01;
        exp_jobs[2] = 3'b0_10;
        exp_jobs[3] = 3'b1_10;
        exp_jobs[4] = 3'b1_01;
        vecs = 0;
        errs = 0;
        bus.prendido = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_color = 1'b0;
        bus.req_pages = 2'd0;
        bus.fin_color = 1'b0;
        bus.fin_negro = 1'b0;
        bus.error_color = 1'b0;
        bus.error_negro = 1'b0;
        reset = 1'b1;
        #3;
        model_reset();
        check_outputs();
        #20;
        reset = 1'b0;
        tick();

        // single color job, two pages
        req(1'b1, 2'd2);
        tick();
        chk("t1_start_color", 32'(bus.start_color), 32'd1);
        chk("t1_pagina", 32'(bus.pagina), 32'd2);
        tick();
        chk("t1_start_once", 32'(bus.start_color), 32'd0);
        chk("t1_pagina_held", 32'(bus.pagina), 32'd2);
        bus.fin_color = 1'b1;
        tick();
        bus.fin_color = 1'b0;
        tick();
        chk("t1_busy", 32'(bus.busy), 32'd0);
        chk("t1_jobs_done", 32'(bus.jobs_done), 32'd1);

        // six back-to-back requests with the engine stalled
        base = starts.size();
        nd0 = ndrops;
        req(1'b1, 2'd3);
        req(1'b0, 2'd1);
        req(1'b0, 2'd2);
        req(1'b1, 2'd2);
        req(1'b1, 2'd1);
        chk("t2_full", 32'(bus.queue_full), 32'd1);
        req(1'b0, 2'd3);
        chk("t2_drop_pulse", 32'(bus.req_drop), 32'd1);
        tick();
        chk("t2_drop_count", 32'(ndrops - nd0), 32'd1);
        job_fin();
        repeat (4) serve();
        chk("t2_start_count", 32'(starts.size() - base), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t2_order%0d", i), 32'(starts[base + i]), 32'(exp_jobs[i]));

        // black job out of ink for six cycles while the color engine also reports error
        req(1'b0, 2'd3);
        tick();
        tick();
        bus.error_negro = 1'b1;
        bus.error_color = 1'b1;
        nh = 0;
        ns = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.halted) nh++;
            if (bus.start_negro || bus.start_color) ns++;
        end
        chk("t3_halted_cycles", 32'(nh), 32'd6);
        chk("t3_no_restart", 32'(ns), 32'd0);
        bus.error_negro = 1'b0;
        tick();
        chk("t3_back_to_wait", 32'(bus.halted), 32'd0);
        bus.fin_negro = 1'b1;
        tick();
        bus.fin_negro = 1'b0;
        bus.error_color = 1'b0;
        tick();
        chk("t3_idle", 32'(bus.busy), 32'd0);

        // illegal page code
        req(1'b1, 2'd0);
        chk("t4_drop", 32'(bus.req_drop), 32'd1);
        chk("t4_empty", 32'(bus.queue_empty), 32'd1);
        tick();
        chk("t4_drop_once", 32'(bus.req_drop), 32'd0);

        // power drop with one job waiting and three queued
        req(1'b1, 2'd1);
        tick();
        req(1'b0, 2'd2);
        req(1'b1, 2'd3);
        req(1'b0, 2'd1);
        jd_keep = mdone;
        base = starts.size();
        bus.prendido = 1'b0;
        tick();
        bus.prendido = 1'b1;
        chk("t5_empty", 32'(bus.queue_empty), 32'd1);
        chk("t5_idle", 32'(bus.busy), 32'd0);
        chk("t5_pagina", 32'(bus.pagina), 32'd0);
        chk("t5_jobs_kept", 32'(bus.jobs_done), 32'(jd_keep % (1 << CNT_W)));
        repeat (3) tick();
        chk("t5_no_starts", 32'(starts.size() - base), 32'd0);

        // random traffic, engine levels and occasional power loss
        for (int i = 0; i < 400; i++) begin
            bus.prendido    = ($urandom_range(0, 19) != 0);
            bus.req_valid   = 1'($urandom_range(0, 1));
            bus.req_color   = 1'($urandom_range(0, 1));
            bus.req_pages   = 2'($urandom_range(0, 3));
            bus.fin_color   = ($urandom_range(0, 3) == 0);
            bus.fin_negro   = ($urandom_range(0, 3) == 0);
            bus.error_color = ($urandom_range(0, 4) == 0);
            bus.error_negro = ($urandom_range(0, 4) == 0);
            tick();
        end
        bus.req_valid = 1'b0;
        bus.fin_color = 1'b0;
        bus.fin_negro = 1'b0;
        bus.error_color = 1'b0;
        bus.error_negro = 1'b0;
        bus.prendido = 1'b0;
        tick();
        bus.prendido = 1'b1;
        tick();

        // sixteen completions cross the 15 -> 0 wrap exactly once
        jd_keep = mdone;
        nw0 = nwrap;
        for (int i = 0; i < 16; i++) begin
            req(1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)));
            serve();
        end
        tick();
        chk("t6_wrap_seen", 32'(nwrap - nw0), 32'd1);
        chk("t6_jobs_mod", 32'(bus.jobs_done), 32'(jd_keep % (1 << CNT_W)));

        // asynchronous reset in the middle of a wait
        req(1'b1, 2'd2);
        tick();
        tick();
        chk("t7_busy_before", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("t7_busy", 32'(bus.busy), 32'd0);
        chk("t7_pagina", 32'(bus.pagina), 32'd0);
        chk("t7_empty", 32'(bus.queue_empty), 32'd1);
        chk("t7_jobs_done", 32'(bus.jobs_done), 32'd0);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
